// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with forwarding resolution, ALU operand muxing
// and load-use hazard detection for the pipelined RV32I core.
module id_ex_stage #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    input  logic [XLEN-1:0] RD1D,
    input  logic [XLEN-1:0] RD2D,
    input  logic [XLEN-1:0] ImmExtD,
    input  logic [XLEN-1:0] PCD,
    input  logic [XLEN-1:0] PCPlus4D,
    input  logic [RA_W-1:0] Rs1D,
    input  logic [RA_W-1:0] Rs2D,
    input  logic [RA_W-1:0] RdD,
    input  logic [2:0]      ALUControlD,
    input  logic            ALUSrcD,
    input  logic            RegWriteD,
    input  logic            MemWriteD,
    input  logic            BranchD,
    input  logic            JumpD,
    input  logic [1:0]      ResultSrcD,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] ResultW,
    input  logic [RA_W-1:0] RdM,
    input  logic [RA_W-1:0] RdW,
    input  logic            RegWriteM,
    input  logic            RegWriteW,
    output logic [XLEN-1:0] SrcAE,
    output logic [XLEN-1:0] SrcBE,
    output logic [XLEN-1:0] WriteDataE,
    output logic [2:0]      ALUControlE,
    output logic [RA_W-1:0] RdE,
    output logic [RA_W-1:0] Rs1E,
    output logic [RA_W-1:0] Rs2E,
    output logic            RegWriteE,
    output logic            MemWriteE,
    output logic            BranchE,
    output logic            JumpE,
    output logic [1:0]      ResultSrcE,
    output logic [XLEN-1:0] PCE,
    output logic [XLEN-1:0] PCPlus4E,
    output logic [1:0]      ForwardAE,
    output logic [1:0]      ForwardBE,
    output logic            lwStallD
);

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_W   = 2'b01;
    localparam logic [1:0] FWD_M   = 2'b10;

    logic [XLEN-1:0] rd1_e, rd2_e, imm_e, pc_e, pc_plus4_e;
    logic [RA_W-1:0] rs1_e, rs2_e, rd_e;
    logic [2:0]      alu_control_e;
    logic            alu_src_e, reg_write_e, mem_write_e, branch_e, jump_e;
    logic [1:0]      result_src_e;

    // E register bank: reset/flush load a bubble, stall holds, otherwise capture D
    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            rd1_e         <= '0;
            rd2_e         <= '0;
            imm_e         <= '0;
            pc_e          <= '0;
            pc_plus4_e    <= '0;
            rs1_e         <= '0;
            rs2_e         <= '0;
            rd_e          <= '0;
            alu_control_e <= 3'b000;
            alu_src_e     <= 1'b0;
            reg_write_e   <= 1'b0;
            mem_write_e   <= 1'b0;
            branch_e      <= 1'b0;
            jump_e        <= 1'b0;
            result_src_e  <= 2'b00;
        end else if (!StallE) begin
            rd1_e         <= RD1D;
            rd2_e         <= RD2D;
            imm_e         <= ImmExtD;
            pc_e          <= PCD;
            pc_plus4_e    <= PCPlus4D;
            rs1_e         <= Rs1D;
            rs2_e         <= Rs2D;
            rd_e          <= RdD;
            alu_control_e <= ALUControlD;
            alu_src_e     <= ALUSrcD;
            reg_write_e   <= RegWriteD;
            mem_write_e   <= MemWriteD;
            branch_e      <= BranchD;
            jump_e        <= JumpD;
            result_src_e  <= ResultSrcD;
        end
    end

    // While reset is high the in-flight E instruction is hidden immediately,
    // not just from the next edge onward.
    logic            live;
    logic [XLEN-1:0] rd1_v, rd2_v, imm_v;
    logic [RA_W-1:0] rs1_v, rs2_v, rd_v;
    logic            alu_src_v;
    logic [1:0]      result_src_v;

    assign live         = ~reset;
    assign rd1_v        = live ? rd1_e : '0;
    assign rd2_v        = live ? rd2_e : '0;
    assign imm_v        = live ? imm_e : '0;
    assign rs1_v        = live ? rs1_e : '0;
    assign rs2_v        = live ? rs2_e : '0;
    assign rd_v         = live ? rd_e : '0;
    assign alu_src_v    = live & alu_src_e;
    assign result_src_v = live ? result_src_e : 2'b00;

    assign ALUControlE = live ? alu_control_e : 3'b000;
    assign RdE         = rd_v;
    assign Rs1E        = rs1_v;
    assign Rs2E        = rs2_v;
    assign RegWriteE   = live & reg_write_e;
    assign MemWriteE   = live & mem_write_e;
    assign BranchE     = live & branch_e;
    assign JumpE       = live & jump_e;
    assign ResultSrcE  = result_src_v;
    assign PCE         = live ? pc_e : '0;
    assign PCPlus4E    = live ? pc_plus4_e : '0;

    // Forward select: Memory stage beats Writeback, x0 never forwarded
    always_comb begin
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;
        if (RegWriteM && (RdM != '0) && (RdM == rs1_v)) begin
            ForwardAE = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs1_v)) begin
            ForwardAE = FWD_W;
        end
        if (RegWriteM && (RdM != '0) && (RdM == rs2_v)) begin
            ForwardBE = FWD_M;
        end else if (RegWriteW && (RdW != '0) && (RdW == rs2_v)) begin
            ForwardBE = FWD_W;
        end
    end

    // Operand muxes: forwarded rs1/rs2, then immediate select for SrcB
    always_comb begin
        SrcAE      = rd1_v;
        WriteDataE = rd2_v;
        case (ForwardAE)
            FWD_M:   SrcAE = ALUResultM;
            FWD_W:   SrcAE = ResultW;
            default: SrcAE = rd1_v;
        endcase
        case (ForwardBE)
            FWD_M:   WriteDataE = ALUResultM;
            FWD_W:   WriteDataE = ResultW;
            default: WriteDataE = rd2_v;
        endcase
        SrcBE = alu_src_v ? imm_v : WriteDataE;
    end

    // Load in E whose destination is read by the instruction in D
    assign lwStallD = result_src_v[0] && (rd_v != '0) &&
                      ((rd_v == Rs1D) || (rd_v == Rs2D));

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and execute-operand selection for the pipelined RV32I core.
- Captures decoded operands and control from Decode and resolves forwarding from the Memory and Writeback stages.
- Drives SrcA, SrcB and the 3-bit ALU control straight into the ALU.
- Detects load-use hazards for the hazard unit.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- StallE  in  1  hold all E registers.
- FlushE  in  1  load a bubble into E.
- RD1D, RD2D  in  XLEN  register-file read data.
- ImmExtD  in  XLEN  extended immediate.
- PCD, PCPlus4D  in  XLEN  PC and PC+4.
- Rs1D, Rs2D, RdD  in  RA_W  register addresses.
- ALUControlD  in  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- ALUSrcD  in  1  1 selects immediate for SrcB.
- RegWriteD, MemWriteD, BranchD, JumpD  in  1  control bits.
- ResultSrcD  in  2  00 ALU, 01 memory, 10 PC+4.
- ALUResultM  in  XLEN  Memory-stage forward value.
- ResultW  in  XLEN  Writeback-stage forward value.
- RdM, RdW  in  RA_W  destination registers in M and W.
- RegWriteM, RegWriteW  in  1  write enables in M and W.
- SrcAE, SrcBE  out  XLEN  ALU operands.
- WriteDataE  out  XLEN  forwarded rs2 value for stores.
- ALUControlE  out  3  registered ALU op.
- RdE, Rs1E, Rs2E  out  RA_W  registered addresses.
- RegWriteE, MemWriteE, BranchE, JumpE  out  1  registered control bits.
- ResultSrcE  out  2  registered result select.
- PCE, PCPlus4E  out  XLEN  registered PC values.
- ForwardAE, ForwardBE  out  2  00 register, 01 W, 10 M.
- lwStallD  out  1  load-use hazard detected.

Behaviour:
- Register update on rising clk, priority order:
  - reset: every E register cleared to 0.
  - else FlushE: bubble, every E register cleared to 0. FlushE wins over StallE when both are asserted.
  - else StallE: all E registers hold their value.
  - else: all D inputs are captured.
- Reset and bubble values: ALUControlE=000, all control bits 0, RdE/Rs1E/Rs2E=0, all data registers 0. SrcAE/SrcBE are then 0 unless forwarding selects a value.
- Latency: one cycle from D inputs to E registers. Forwarding and the operand muxes are combinational from the E registers and the M/W inputs.
- ForwardAE:
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - else 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - else 00.
  - M has priority over W.
- ForwardBE: same rule using Rs2E.
- Register x0 is never forwarded.
- SrcAE = forwarded RD1E.
- WriteDataE = forwarded RD2E, regardless of ALUSrcE.
- SrcBE = ImmExtE when ALUSrcE=1, else WriteDataE.
- lwStallD = ResultSrcE[0] && RdE!=0 && (RdE==Rs1D || RdE==Rs2D). It is combinational and is 0 during reset and after a flush.
- The block performs no arithmetic; widths pass through unchanged.
- A reset asserted mid-stream discards the in-flight E instruction within the same cycle.

Test Plan:
- Reset held 2 cycles with random D inputs -> all E outputs 0, ForwardAE/BE=00, lwStallD=0.
- Capture: RD1D=5, RD2D=7, ALUSrcD=0, no M/W writes -> next cycle SrcAE=5, SrcBE=7, WriteDataE=7. Repeat with ALUSrcD=1, ImmExtD=0xFFFFFFF0 -> SrcBE=0xFFFFFFF0, WriteDataE=7.
- Forward priority: Rs1E=3, RdM=3, RegWriteM=1, ALUResultM=0xAA, RdW=3, RegWriteW=1, ResultW=0xBB -> ForwardAE=10, SrcAE=0xAA. Drop RegWriteM -> ForwardAE=01, SrcAE=0xBB.
- x0: Rs2E=0, RdM=0, RegWriteM=1 -> ForwardBE=00, SrcBE=RD2E.
- StallE=1 for 2 cycles with changing D inputs -> E outputs frozen. StallE=1 with FlushE=1 -> bubble, RegWriteE=0.
- Load-use: ResultSrcE=01, RdE=4, Rs2D=4 -> lwStallD=1. RdE=0 -> lwStallD=0. ResultSrcE=00 -> lwStallD=0.
